hazard_ctrl_sb: RTL and testbench

//  Parametrised pipeline hazard controller for the 5-stage MIPS core with variable load latency.

---
 rtl/core_pkg.sv | 30 +++
 rtl/load_scoreboard.sv | 64 ++++++
 rtl/hazard_ctrl_sb.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl_sb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_e  : controller FSM states
//   sb_entry_t  : one load-scoreboard slot {valid, destination register},
//                 shown at the core's default register-address width
//   SB_DEPTH    : scoreboard depth for the core's default load latency
//   sb_depth()  : scoreboard depth for any load latency; a load stays
//                 visible for its LOAD_LAT stall slots plus one
//                 forwardable slot
package core_pkg;

    localparam int DEF_RA_W     = 5;
    localparam int DEF_LOAD_LAT = 1;
    localparam int SB_DEPTH     = DEF_LOAD_LAT + 1;

    typedef enum logic [1:0] {
        RUN,
        FREEZE,
        REDIRECT
    } hz_state_e;

    typedef struct packed {
        logic                v;
        logic [DEF_RA_W-1:0] rd;
    } sb_entry_t;

    function automatic int sb_depth(input int load_lat);
        return load_lat + 1;
    endfunction

endpackage

// File: rtl/load_scoreboard.sv
// Shift-register scoreboard of in-flight loads plus load-use match logic.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   shift       : advance one slot (pipe enabled)
//   load_v      : a surviving load is entering EX this cycle
//   load_rd     : its destination register
//   rs, rt      : ID-stage source registers
//   use_rs/rt   : ID instruction actually reads that source
//   hit         : a source depends on a load whose data is not yet forwardable
module load_scoreboard
    import core_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            shift,
    input  logic            load_v,
    input  logic [RA_W-1:0] load_rd,
    input  logic [RA_W-1:0] rs,
    input  logic [RA_W-1:0] rt,
    input  logic            use_rs,
    input  logic            use_rt,
    output logic            hit
);

    localparam int DEPTH = sb_depth(LOAD_LAT);

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] rd;
    } slot_t;

    slot_t slots [DEPTH];

    // Slot index equals cycles since the load left EX; frozen cycles hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (shift) begin
            slots[0] <= '{v: load_v, rd: load_rd};
            for (int i = 1; i < DEPTH; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

    // Only the first LOAD_LAT slots stall; the last slot is forwardable.
    // r0 is hard-wired zero so a load to it never creates a dependency.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (slots[i].v && (slots[i].rd != '0) &&
                ((use_rs && (slots[i].rd == rs)) ||
                 (use_rt && (slots[i].rd == rt)))) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard controller for the 5-stage core with variable load latency.
// Generates load-use stalls, freezes on D-cache busy, defers EX redirects
// that arrive while frozen, and counts stall cycles.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   i_rs_id/i_rt_id   : ID sources;  i_use_rs_id/i_use_rt_id : sources used
//   i_ld_ex, i_rd_ex  : load entering EX and its destination
//   i_dmem_busy       : D-cache not ready, whole pipe freezes
//   i_redirect_ex     : EX mispredict / JR resolved
//   i_jump_id         : J/JAL in ID;  i_pred_tk_if : predicted-taken fetch
//   o_pc_en, o_ifid_en, o_pipe_en           : stage enables
//   o_flush_ifid, o_flush_idex, o_flush_exmem : stage flushes
//   o_stall_cnt       : saturating count of cycles with o_pc_en low
module hazard_ctrl_sb
    import core_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RA_W-1:0]  i_rs_id,
    input  logic [RA_W-1:0]  i_rt_id,
    input  logic             i_use_rs_id,
    input  logic             i_use_rt_id,
    input  logic             i_ld_ex,
    input  logic [RA_W-1:0]  i_rd_ex,
    input  logic             i_dmem_busy,
    input  logic             i_redirect_ex,
    input  logic             i_jump_id,
    input  logic             i_pred_tk_if,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_pipe_en,
    output logic             o_flush_ifid,
    output logic             o_flush_idex,
    output logic             o_flush_exmem,
    output logic [CNT_W-1:0] o_stall_cnt
);

    hz_state_e        state;
    hz_state_e        state_nxt;
    logic             pending;
    logic             pending_nxt;
    logic             hit;
    logic [CNT_W-1:0] stall_cnt;

    // A load killed by the ID/EX bubble (stall or redirect) never enters.
    load_scoreboard #(
        .RA_W    (RA_W),
        .LOAD_LAT(LOAD_LAT)
    ) u_sb (
        .clk    (clk),
        .rst_n  (rst_n),
        .shift  (o_pipe_en),
        .load_v (i_ld_ex & ~o_flush_idex),
        .load_rd(i_rd_ex),
        .rs     (i_rs_id),
        .rt     (i_rt_id),
        .use_rs (i_use_rs_id),
        .use_rt (i_use_rt_id),
        .hit    (hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            pending   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (!o_pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // Busy overrides everything; a redirect seen while frozen is remembered
    // and replayed as a single flush cycle after the release cycle.
    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        o_pc_en       = 1'b1;
        o_ifid_en     = 1'b1;
        o_pipe_en     = 1'b1;
        o_flush_ifid  = 1'b0;
        o_flush_idex  = 1'b0;
        o_flush_exmem = 1'b0;

        if (i_dmem_busy) begin
            o_pc_en     = 1'b0;
            o_ifid_en   = 1'b0;
            o_pipe_en   = 1'b0;
            state_nxt   = FREEZE;
            pending_nxt = pending | i_redirect_ex;
        end else begin
            case (state)
                FREEZE:   state_nxt = pending ? REDIRECT : RUN;
                REDIRECT: begin
                    state_nxt   = RUN;
                    pending_nxt = 1'b0;
                end
                default:  state_nxt = RUN;
            endcase

            if ((state == REDIRECT) || i_redirect_ex) begin
                o_flush_ifid  = 1'b1;
                o_flush_idex  = 1'b1;
                o_flush_exmem = 1'b1;
            end else if (hit) begin
                o_pc_en      = 1'b0;
                o_ifid_en    = 1'b0;
                o_flush_idex = 1'b1;
            end else if (i_jump_id || i_pred_tk_if) begin
                o_flush_ifid = 1'b1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Self-checking bench: two controllers (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4) share one stimulus stream and are compared against a
// list-of-loads reference model every cycle.
module tb_hazard_ctrl_sb;

    localparam int RA_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [RA_W-1:0] rs_id, rt_id, rd_ex;
    logic            use_rs, use_rt, ld_ex, busy, redirect, jump, pred;

    logic        a_pc, a_ifid, a_pipe, a_fifid, a_fidex, a_fexmem;
    logic [15:0] a_cnt;
    logic        b_pc, b_ifid, b_pipe, b_fifid, b_fidex, b_fexmem;
    logic [3:0]  b_cnt;

    hazard_ctrl_sb #(.RA_W(RA_W), .LOAD_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_rs_id(rs_id), .i_rt_id(rt_id),
        .i_use_rs_id(use_rs), .i_use_rt_id(use_rt),
        .i_ld_ex(ld_ex), .i_rd_ex(rd_ex),
        .i_dmem_busy(busy), .i_redirect_ex(redirect),
        .i_jump_id(jump), .i_pred_tk_if(pred),
        .o_pc_en(a_pc), .o_ifid_en(a_ifid), .o_pipe_en(a_pipe),
        .o_flush_ifid(a_fifid), .o_flush_idex(a_fidex), .o_flush_exmem(a_fexmem),
        .o_stall_cnt(a_cnt)
    );

    hazard_ctrl_sb #(.RA_W(RA_W), .LOAD_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_rs_id(rs_id), .i_rt_id(rt_id),
        .i_use_rs_id(use_rs), .i_use_rt_id(use_rt),
        .i_ld_ex(ld_ex), .i_rd_ex(rd_ex),
        .i_dmem_busy(busy), .i_redirect_ex(redirect),
        .i_jump_id(jump), .i_pred_tk_if(pred),
        .o_pc_en(b_pc), .o_ifid_en(b_ifid), .o_pipe_en(b_pipe),
        .o_flush_ifid(b_fifid), .o_flush_idex(b_fidex), .o_flush_exmem(b_fexmem),
        .o_stall_cnt(b_cnt)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: each in-flight load is a record with its age in
    // pipe-advancing cycles; it blocks a reader while age < latency.
    typedef struct {
        int dut;
        int rd;
        int age;
    } load_t;

    load_t      inflight[$];
    int         lat[2]      = '{1, 3};
    int         cnt_max[2]  = '{65535, 15};
    bit         owe[2];
    bit         flush_turn[2];
    bit         was_busy[2];
    int         stalls[2];
    logic [5:0] exp_flags[2];

    // Flag order: {pc_en, ifid_en, pipe_en, flush_ifid, flush_idex, flush_exmem}
    function automatic logic [5:0] flagsA();
        return {a_pc, a_ifid, a_pipe, a_fifid, a_fidex, a_fexmem};
    endfunction

    function automatic logic [5:0] flagsB();
        return {b_pc, b_ifid, b_pipe, b_fifid, b_fidex, b_fexmem};
    endfunction

    function automatic bit modelHit(int d);
        bit h = 1'b0;
        foreach (inflight[k]) begin
            if (inflight[k].dut == d && inflight[k].age < lat[d] && inflight[k].rd != 0 &&
                ((use_rs && inflight[k].rd == int'(rs_id)) ||
                 (use_rt && inflight[k].rd == int'(rt_id))))
                h = 1'b1;
        end
        return h;
    endfunction

    task automatic modelOutputs();
        for (int d = 0; d < 2; d++) begin
            if (busy)
                exp_flags[d] = 6'b000000;
            else if (flush_turn[d] || redirect)
                exp_flags[d] = 6'b111111;
            else if (modelHit(d))
                exp_flags[d] = 6'b001010;
            else
                exp_flags[d] = {3'b111, jump | pred, 2'b00};
        end
    endtask

    task automatic modelEdge();
        if (!rst_n) begin
            inflight.delete();
            for (int d = 0; d < 2; d++) begin
                owe[d] = 0; flush_turn[d] = 0; was_busy[d] = 0; stalls[d] = 0;
            end
            return;
        end
        for (int d = 0; d < 2; d++) begin
            bit nxt_turn;
            if (!exp_flags[d][5] && stalls[d] < cnt_max[d]) stalls[d]++;
            if (exp_flags[d][3]) begin
                for (int k = 0; k < inflight.size(); k++)
                    if (inflight[k].dut == d) inflight[k].age++;
                for (int k = inflight.size() - 1; k >= 0; k--)
                    if (inflight[k].dut == d && inflight[k].age > lat[d]) inflight.delete(k);
                if (ld_ex && !exp_flags[d][1])
                    inflight.push_back('{dut: d, rd: int'(rd_ex), age: 0});
            end
            nxt_turn = 0;
            if (busy) owe[d] = owe[d] | redirect;
            else if (flush_turn[d]) owe[d] = 0;
            else if (was_busy[d] && owe[d]) nxt_turn = 1;
            flush_turn[d] = nxt_turn;
            was_busy[d]   = busy;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input bit b, input bit rdr, input bit jmp, input bit prd,
                                 input bit ld, input int rd, input bit urs, input int rs,
                                 input bit urt, input int rt);
        busy = b; redirect = rdr; jump = jmp; pred = prd;
        ld_ex = ld; rd_ex = RA_W'(rd);
        use_rs = urs; rs_id = RA_W'(rs);
        use_rt = urt; rt_id = RA_W'(rt);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called at a negedge with inputs already applied.
    task automatic runCycle(input string tag);
        modelOutputs();
        #1;
        if (rst_n) begin
            checkOutput({tag, " flags_a"}, 32'(flagsA()), 32'(exp_flags[0]));
            checkOutput({tag, " flags_b"}, 32'(flagsB()), 32'(exp_flags[1]));
            checkOutput({tag, " cnt_a"}, 32'(a_cnt), 32'(stalls[0]));
            checkOutput({tag, " cnt_b"}, 32'(b_cnt), 32'(stalls[1]));
        end
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic checkCounts(input string tag, input int ea, input int eb);
        checkOutput({tag, " cnt_a"}, 32'(a_cnt), 32'(ea));
        checkOutput({tag, " cnt_b"}, 32'(b_cnt), 32'(eb));
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        runCycle("rst");
        runCycle("rst");
        rst_n = 1'b1;
        checkOutput("reset flags_a", 32'(flagsA()), 32'h38);
        checkOutput("reset flags_b", 32'(flagsB()), 32'h38);
        checkCounts("reset", 0, 0);

        $display("[TB] load-use on rs");
        applyStimulus(0, 0, 0, 0, 1, 8, 0, 0, 0, 0);
        runCycle("t1 ld");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 8, 0, 0);
        #1;
        checkOutput("t1 stall flags_a", 32'(flagsA()), 32'h0A);
        runCycle("t1 use");
        for (int i = 0; i < 3; i++) runCycle("t1 use");
        checkCounts("t1", 1, 3);

        $display("[TB] load to r0 and load-use on rt");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        runCycle("r0 ld");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) runCycle("r0 use");
        checkCounts("r0", 1, 3);
        applyStimulus(0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        runCycle("rt ld");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        for (int i = 0; i < 4; i++) runCycle("rt use");
        idle();
        runCycle("drain");
        runCycle("drain");
        checkCounts("rt", 2, 6);

        $display("[TB] freeze with deferred redirect");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("frz");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("frz redir");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("frz");
        runCycle("frz");
        idle();
        #1;
        checkOutput("release flags_a", 32'(flagsA()), 32'h38);
        runCycle("release");
        #1;
        checkOutput("redirect flags_b", 32'(flagsB()), 32'h3F);
        runCycle("redirect");
        checkOutput("after redirect flags_a", 32'(flagsA()), 32'h38);
        checkCounts("frz", 6, 10);

        $display("[TB] redirect beats load-use");
        applyStimulus(0, 0, 0, 0, 1, 10, 0, 0, 0, 0);
        runCycle("t4 ld");
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 10, 0, 0);
        #1;
        checkOutput("t4 flags_a", 32'(flagsA()), 32'h3F);
        checkOutput("t4 flags_b", 32'(flagsB()), 32'h3F);
        runCycle("t4 redir");
        idle();
        for (int i = 0; i < 3; i++) runCycle("t4 drain");
        checkCounts("t4", 6, 10);

        $display("[TB] jump alone and during stall");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("jump flags_a", 32'(flagsA()), 32'h3C);
        runCycle("jump");
        applyStimulus(0, 0, 0, 0, 1, 11, 0, 0, 0, 0);
        runCycle("t5 ld");
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 11, 0, 0);
        #1;
        checkOutput("jump stall flags_a", 32'(flagsA()), 32'h0A);
        runCycle("jump stall");
        #1;
        checkOutput("jump reseen flags_a", 32'(flagsA()), 32'h3C);
        runCycle("jump reseen");
        idle();
        for (int i = 0; i < 3; i++) runCycle("t5 drain");
        checkCounts("t5", 7, 12);

        $display("[TB] counter saturation");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) runCycle("sat");
        idle();
        runCycle("sat release");
        checkCounts("sat", 27, 15);

        $display("[TB] reset mid-freeze");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("rf frz");
        rst_n = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("rf rst");
        rst_n = 1'b1;
        idle();
        checkCounts("rf", 0, 0);
        runCycle("rf idle");
        runCycle("rf idle");
        checkOutput("rf no redirect flags_a", 32'(flagsA()), 32'h38);
        checkOutput("rf no redirect flags_b", 32'(flagsB()), 32'h38);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            applyStimulus(($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                          ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)),
                          ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)));
            runCycle("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
